// File: rtl/uart_start_detect.sv
`timescale 1ns / 1ps
// uart_start_detect: start-bit detector for the serial receive path.
//
// Synchronises the raw serial line, ignores it for a short quiet period after
// reset, then qualifies a start edge by re-checking the line at mid-bit on the
// oversample tick. A confirmed start raises enable_o until the receiver reports
// frame_done_i or MAX_TICKS oversample ticks elapse since the start edge.
//
// Parameters:
//   OSR          oversample ticks per bit (even, >= 4)
//   QUIET_CYCLES clk cycles after reset release with detection disabled (>= 1)
//   MAX_TICKS    ticks after the start edge before a forced timeout (> OSR/2)
//   IDLE_LEVEL   idle level of the line; a start bit is the opposite level
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   in_i           raw serial line, asynchronous to clk_i
//   sample_tick_i  oversample strobe, one clk wide
//   frame_done_i   receiver finished its frame (pulse)
//   enable_o       level, high while a confirmed frame is in progress
//   start_o        pulse, start bit confirmed
//   false_start_o  pulse, start edge rejected as a glitch
//   timeout_o      pulse, MAX_TICKS reached without frame_done_i
//   tick_cnt_o     ticks since the start edge, 0 while quiet or idle
//   false_cnt_o    saturating count of false starts (only with STARTDET_STATS_EN)
//
// Build option: define STARTDET_STATS_EN to add the false_cnt_o statistics port.

module uart_start_detect #(
  parameter int unsigned OSR          = 16,
  parameter int unsigned QUIET_CYCLES = 15,
  parameter int unsigned MAX_TICKS    = 160,
  parameter bit          IDLE_LEVEL   = 1'b1,
  localparam int unsigned CNT_W       = $clog2(MAX_TICKS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_i,
  input  logic             sample_tick_i,
  input  logic             frame_done_i,
  output logic             enable_o,
  output logic             start_o,
  output logic             false_start_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] tick_cnt_o
`ifdef STARTDET_STATS_EN
  ,
  output logic [7:0]       false_cnt_o
`endif
);

  // Quiet counter only needs to reach QUIET_CYCLES-1.
  localparam int unsigned QW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

  localparam logic [QW-1:0]    QuietLast = QW'(QUIET_CYCLES - 1);
  localparam logic [CNT_W-1:0] HalfOsr   = CNT_W'(OSR / 2);
  localparam logic [CNT_W-1:0] MaxTicks  = CNT_W'(MAX_TICKS);

  typedef enum logic [1:0] {
    StQuiet,
    StIdle,
    StVerify,
    StActive
  } state_e;

  state_e           state_q, state_d;
  logic [QW-1:0]    quiet_cnt_q, quiet_cnt_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [CNT_W-1:0] tick_cnt_inc;
  logic             enable_q, enable_d;
  logic             start_q, start_d;
  logic             false_start_q, false_start_d;
  logic             timeout_q, timeout_d;
  logic [1:0]       sync_q;
  logic             in_s;
  logic             active;

  // Two-flop synchroniser; resets to the idle level so reset never looks like a start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {2{IDLE_LEVEL}};
    end else begin
      sync_q <= {sync_q[0], in_i};
    end
  end

  assign in_s         = sync_q[1];
  assign active       = (in_s != IDLE_LEVEL);
  assign tick_cnt_inc = tick_cnt_q + CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    quiet_cnt_d   = quiet_cnt_q;
    tick_cnt_d    = tick_cnt_q;
    enable_d      = enable_q;
    start_d       = 1'b0;
    false_start_d = 1'b0;
    timeout_d     = 1'b0;

    unique case (state_q)
      StQuiet: begin
        tick_cnt_d = '0;
        enable_d   = 1'b0;
        // Saturate at the last value so the counter can never wrap.
        if (quiet_cnt_q == QuietLast) begin
          state_d = StIdle;
        end else begin
          quiet_cnt_d = quiet_cnt_q + QW'(1);
        end
      end

      StIdle: begin
        tick_cnt_d = '0;
        enable_d   = 1'b0;
        if (sample_tick_i && active) begin
          tick_cnt_d = CNT_W'(1);
          state_d    = StVerify;
        end
      end

      StVerify: begin
        if (sample_tick_i) begin
          if (!active) begin
            false_start_d = 1'b1;
            tick_cnt_d    = '0;
            state_d       = StIdle;
          end else begin
            tick_cnt_d = tick_cnt_inc;
            if (tick_cnt_inc == HalfOsr) begin
              start_d  = 1'b1;
              enable_d = 1'b1;
              state_d  = StActive;
            end
          end
        end
      end

      StActive: begin
        // frame_done_i takes priority over a coincident timeout tick.
        if (frame_done_i) begin
          enable_d   = 1'b0;
          tick_cnt_d = '0;
          state_d    = StIdle;
        end else if (sample_tick_i) begin
          if (tick_cnt_inc == MaxTicks) begin
            timeout_d  = 1'b1;
            enable_d   = 1'b0;
            tick_cnt_d = '0;
            state_d    = StIdle;
          end else begin
            tick_cnt_d = tick_cnt_inc;
          end
        end
      end

      default: begin
        state_d    = StQuiet;
        tick_cnt_d = '0;
        enable_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StQuiet;
      quiet_cnt_q   <= '0;
      tick_cnt_q    <= '0;
      enable_q      <= 1'b0;
      start_q       <= 1'b0;
      false_start_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      quiet_cnt_q   <= quiet_cnt_d;
      tick_cnt_q    <= tick_cnt_d;
      enable_q      <= enable_d;
      start_q       <= start_d;
      false_start_q <= false_start_d;
      timeout_q     <= timeout_d;
    end
  end

  assign enable_o      = enable_q;
  assign start_o       = start_q;
  assign false_start_o = false_start_q;
  assign timeout_o     = timeout_q;
  assign tick_cnt_o    = tick_cnt_q;

`ifdef STARTDET_STATS_EN
  logic [7:0] false_cnt_q, false_cnt_d;

  // Counts alongside the false_start pulse so both appear on the same edge.
  always_comb begin
    false_cnt_d = false_cnt_q;
    if (false_start_d && (false_cnt_q != 8'hFF)) begin
      false_cnt_d = false_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      false_cnt_q <= 8'h00;
    end else begin
      false_cnt_q <= false_cnt_d;
    end
  end

  assign false_cnt_o = false_cnt_q;
`else
  // Statistics counter not built.
`endif

endmodule

// File: tb/tb_uart_start_detect.sv
`timescale 1ns / 1ps
// Directed testbench for uart_start_detect with default parameters.
// Inputs change 1ns after a rising edge; outputs are read at that same point.

module tb_uart_start_detect;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       in_i;
  logic       sample_tick_i;
  logic       frame_done_i;
  logic       enable_o;
  logic       start_o;
  logic       false_start_o;
  logic       timeout_o;
  logic [7:0] tick_cnt_o;
`ifdef STARTDET_STATS_EN
  logic [7:0] false_cnt_o;
`endif

  uart_start_detect dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .in_i          (in_i),
    .sample_tick_i (sample_tick_i),
    .frame_done_i  (frame_done_i),
    .enable_o      (enable_o),
    .start_o       (start_o),
    .false_start_o (false_start_o),
    .timeout_o     (timeout_o),
    .tick_cnt_o    (tick_cnt_o)
`ifdef STARTDET_STATS_EN
    ,
    .false_cnt_o   (false_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse tallies, sampled on the falling edge.
  int n_start = 0;
  int n_false = 0;
  int n_tmo   = 0;

  int tick_div   = 1;
  int tick_phase = 0;

  int base_start;
  int base_false;
  int base_tmo;

  always @(negedge clk_i) begin
    if (rst_ni === 1'b1) begin
      if (start_o)       n_start++;
      if (false_start_o) n_false++;
      if (timeout_o)     n_tmo++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, driving sample_tick_i every tick_div-th edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      sample_tick_i = (tick_phase == 0);
      @(posedge clk_i);
      #1;
      tick_phase = (tick_phase + 1 >= tick_div) ? 0 : tick_phase + 1;
    end
  endtask

  task automatic end_frame();
    in_i = 1'b1;
    step(3);
    frame_done_i = 1'b1;
    step(1);
    frame_done_i = 1'b0;
    step(5);
  endtask

  task automatic snap();
    base_start = n_start;
    base_false = n_false;
    base_tmo   = n_tmo;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni        = 1'b0;
    in_i          = 1'b0;
    sample_tick_i = 1'b1;
    frame_done_i  = 1'b0;
    #23;
    check("rst_enable",   32'(enable_o), 0);
    check("rst_start",    32'(start_o), 0);
    check("rst_false",    32'(false_start_o), 0);
    check("rst_timeout",  32'(timeout_o), 0);
    check("rst_tick_cnt", 32'(tick_cnt_o), 0);

    // 1: line low from reset release
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    step(15);
    check("s1_quiet_tick_cnt", 32'(tick_cnt_o), 0);
    check("s1_quiet_no_start", 32'(n_start), 0);
    step(1);
    check("s1_verify_entry", 32'(tick_cnt_o), 1);
    step(6);
    check("s1_start_early", 32'(start_o), 0);
    step(1);
    check("s1_start",    32'(start_o), 1);
    check("s1_enable",   32'(enable_o), 1);
    check("s1_tick_cnt", 32'(tick_cnt_o), 8);
    end_frame();
    check("s1_done_enable", 32'(enable_o), 0);

    // 2: clean start, frame_done at E+100
    snap();
    in_i = 1'b0;
    step(9);
    check("s2_start_e8", 32'(start_o), 0);
    step(1);
    check("s2_start_e9",  32'(start_o), 1);
    check("s2_enable_e9", 32'(enable_o), 1);
    check("s2_tick_e9",   32'(tick_cnt_o), 8);
    step(6);
    in_i = 1'b1;
    step(84);
    check("s2_tick_e99",   32'(tick_cnt_o), 98);
    check("s2_enable_e99", 32'(enable_o), 1);
    frame_done_i = 1'b1;
    step(1);
    frame_done_i = 1'b0;
    check("s2_enable_done", 32'(enable_o), 0);
    check("s2_tick_done",   32'(tick_cnt_o), 0);
    check("s2_timeout_done", 32'(timeout_o), 0);
    step(5);
    check("s2_start_count", 32'(n_start - base_start), 1);
    check("s2_no_timeout",  32'(n_tmo - base_tmo), 0);
    check("s2_no_false",    32'(n_false - base_false), 0);

    // 3: glitch of 3 clk
    snap();
    in_i = 1'b0;
    step(3);
    in_i = 1'b1;
    step(2);
    check("s3_tick_e4",  32'(tick_cnt_o), 3);
    check("s3_false_e4", 32'(false_start_o), 0);
    step(1);
    check("s3_false_e5", 32'(false_start_o), 1);
    check("s3_tick_e5",  32'(tick_cnt_o), 0);
    step(20);
    check("s3_enable",      32'(enable_o), 0);
    check("s3_no_start",    32'(n_start - base_start), 0);
    check("s3_false_count", 32'(n_false - base_false), 1);
`ifdef STARTDET_STATS_EN
    check("s3_false_cnt", 32'(false_cnt_o), 1);
`endif

    // 4: timeout with no frame_done
    snap();
    in_i = 1'b0;
    step(10);
    check("s4_start", 32'(start_o), 1);
    step(6);
    in_i = 1'b1;
    step(145);
    check("s4_tick_e160",    32'(tick_cnt_o), 159);
    check("s4_enable_e160",  32'(enable_o), 1);
    check("s4_timeout_e160", 32'(timeout_o), 0);
    step(1);
    check("s4_timeout_e161", 32'(timeout_o), 1);
    check("s4_enable_e161",  32'(enable_o), 0);
    check("s4_tick_e161",    32'(tick_cnt_o), 0);
    step(1);
    check("s4_timeout_e162", 32'(timeout_o), 0);
    check("s4_tick_e162",    32'(tick_cnt_o), 0);
    step(5);

    // 5: frame_done on the timeout tick
    snap();
    in_i = 1'b0;
    step(10);
    check("s5_start", 32'(start_o), 1);
    step(6);
    in_i = 1'b1;
    step(145);
    check("s5_tick_e160", 32'(tick_cnt_o), 159);
    frame_done_i = 1'b1;
    step(1);
    frame_done_i = 1'b0;
    check("s5_enable", 32'(enable_o), 0);
    check("s5_timeout", 32'(timeout_o), 0);
    check("s5_tick",   32'(tick_cnt_o), 0);
    step(3);
    check("s5_no_timeout", 32'(n_tmo - base_tmo), 0);

    // 6: async reset mid-ACTIVE
    in_i = 1'b0;
    step(10);
    check("s6_start", 32'(start_o), 1);
    step(20);
    check("s6_tick_pre", 32'(tick_cnt_o), 28);
    #2;
    rst_ni = 1'b0;
    #1;
    check("s6_rst_enable", 32'(enable_o), 0);
    check("s6_rst_tick",   32'(tick_cnt_o), 0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    snap();
`ifdef STARTDET_STATS_EN
    check("s6_false_cnt_clr", 32'(false_cnt_o), 0);
`endif
    step(15);
    check("s6_quiet_tick",     32'(tick_cnt_o), 0);
    check("s6_quiet_no_start", 32'(n_start - base_start), 0);
    step(1);
    check("s6_verify_entry", 32'(tick_cnt_o), 1);
    step(6);
    check("s6_start_early", 32'(start_o), 0);
    step(1);
    check("s6_start_late", 32'(start_o), 1);
    end_frame();

    // 7: sample_tick every 4th clk
    tick_div   = 4;
    tick_phase = 0;
    in_i       = 1'b0;
    step(32);
    check("s7_tick_e31",  32'(tick_cnt_o), 7);
    check("s7_start_e31", 32'(start_o), 0);
    step(1);
    check("s7_start_e32",  32'(start_o), 1);
    check("s7_enable_e32", 32'(enable_o), 1);
    check("s7_tick_e32",   32'(tick_cnt_o), 8);
    step(3);
    check("s7_tick_e35", 32'(tick_cnt_o), 8);
    step(1);
    check("s7_tick_e36", 32'(tick_cnt_o), 9);
    end_frame();
    check("s7_done_enable", 32'(enable_o), 0);
    tick_div   = 1;
    tick_phase = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
